wave_i2s_tx: RTL and testbench

Output stage of the waveform generator chain. Accepts mono samples from the generator/mixer path over a valid/ready handshake, buffers one sample, and serialises each one onto both channels of a standard Philips I2S stream (BCLK, LRCLK, SDATA) toward the board DAC. It derives all serial clocks from the system clock and flags underruns when the upstream stage fails to supply a sample in time.

---
 rtl/wave_i2s_tx.sv | 160 ++++++++++++++++
 tb/tb_wave_i2s_tx.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_i2s_tx.sv
// Philips I2S transmitter: one-entry sample buffer, mono sample sent on both channels.
// Build option WAVE_I2S_UNDERRUN_HOLD_EN: repeat the last sample on underrun instead of muting.
//
// state  | meaning
// S_IDLE | serial outputs held low, waiting for the first buffered sample
// S_RUN  | free-running BCLK/LRCLK frames, one sample loaded per frame
module wave_i2s_tx #(
  parameter int WIDTH    = 24,
  parameter int SLOT     = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_sample_valid,
  output logic             o_sample_ready,
  output logic             o_bclk,
  output logic             o_lrclk,
  output logic             o_sdata,
  output logic             o_underrun
);

  localparam int BW = $clog2(2 * SLOT);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [BW-1:0] B_LAST     = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] LR_LO      = BW'(SLOT - 1);
  localparam logic [BW-1:0] LR_HI      = BW'(2 * SLOT - 2);
  localparam logic [DW-1:0] DIV_RELOAD = DW'(BCLK_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic [BW-1:0]    b_q, b_d;
  logic [DW-1:0]    div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             underrun_q, underrun_d;

  // Serial bit for frame position b: MSB first in each slot, zero padding after WIDTH bits.
  function automatic logic bit_at(input logic [WIDTH-1:0] smp, input logic [BW-1:0] b);
    int               k;
    logic [WIDTH-1:0] sh;
    k = int'(b);
    if (k >= SLOT) k = k - SLOT;
    sh = smp << k;
    return (k < WIDTH) ? sh[WIDTH-1] : 1'b0;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE && hold_full_q) state_d = S_RUN;
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    b_d         = b_q;
    div_d       = div_q;
    bclk_d      = bclk_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;

    if (i_sample_valid && !hold_full_q) begin
      hold_d      = i_sample;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        b_d     = '0;
        div_d   = DIV_RELOAD;
        if (hold_full_q) begin
          frame_d     = hold_q;
          hold_full_d = 1'b0;
          sdata_d     = bit_at(hold_q, '0);
        end
      end
      default: begin
        if (div_q == '0) begin
          div_d  = DIV_RELOAD;
          bclk_d = !bclk_q;
          // Data and word select move only on the falling edge of BCLK.
          if (bclk_q) begin
            if (b_q == B_LAST) begin
              b_d = '0;
              if (hold_full_q) begin
                frame_d     = hold_q;
                hold_full_d = 1'b0;
              end else begin
                underrun_d = 1'b1;
`ifdef WAVE_I2S_UNDERRUN_HOLD_EN
                frame_d = frame_q;
`else
                frame_d = '0;
`endif
              end
            end else begin
              b_d = b_q + BW'(1);
            end
            sdata_d = bit_at(frame_d, b_d);
            lrclk_d = (b_d >= LR_LO) && (b_d <= LR_HI);
          end
        end else begin
          div_d = div_q - DW'(1);
        end
      end
    endcase
  end

  // frame_q doubles as the last-transmitted-sample register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= '0;
      b_q         <= '0;
      div_q       <= DIV_RELOAD;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      b_q         <= b_d;
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_sample_ready = !hold_full_q;
  assign o_bclk         = bclk_q;
  assign o_lrclk        = lrclk_q;
  assign o_sdata        = sdata_q;
  assign o_underrun     = underrun_q;

endmodule

// File: tb/tb_wave_i2s_tx.sv
// Self-checking bench for wave_i2s_tx: frames captured on BCLK rising edges and compared
// against a bit-position model of the I2S frame built from the bench's own samples.
module tb_wave_i2s_tx;
  localparam int WIDTH     = 24;
  localparam int SLOT      = 32;
  localparam int BCLK_DIV  = 2;
  localparam int FBITS     = 2 * SLOT;
  localparam int FRAME_CYC = FBITS * 2 * BCLK_DIV;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic [WIDTH-1:0] sample = '0;
  logic             valid  = 1'b0;
  logic             o_sample_ready, o_bclk, o_lrclk, o_sdata, o_underrun;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;

  wave_i2s_tx #(.WIDTH(WIDTH), .SLOT(SLOT), .BCLK_DIV(BCLK_DIV)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sample      (sample),
    .i_sample_valid(valid),
    .o_sample_ready(o_sample_ready),
    .o_bclk        (o_bclk),
    .o_lrclk       (o_lrclk),
    .o_sdata       (o_sdata),
    .o_underrun    (o_underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: capture {lrclk, sdata} at each BCLK rise, count underrun pulses and ready rises.
  logic       prev_bclk = 1'b0, prev_ur = 1'b0, prev_rdy = 1'b0;
  int         ur_cnt = 0, ur_long = 0, rdy_rise = 0;
  logic [1:0] bitq[$];
  int         stampq[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      bitq.delete();
      stampq.delete();
      prev_bclk <= 1'b0;
    end else begin
      if (o_bclk === 1'b1 && prev_bclk === 1'b0) begin
        bitq.push_back({o_lrclk, o_sdata});
        stampq.push_back(cyc);
      end
      prev_bclk <= o_bclk;
    end
    if (o_underrun === 1'b1) ur_cnt <= ur_cnt + 1;
    if (o_underrun === 1'b1 && prev_ur === 1'b1) ur_long <= ur_long + 1;
    prev_ur <= o_underrun;
    if (o_sample_ready === 1'b1 && prev_rdy !== 1'b1) rdy_rise <= rdy_rise + 1;
    prev_rdy <= o_sample_ready;
  end

  // Reference: position b of a frame carries bit k = b mod SLOT of the sample, MSB first.
  function automatic logic [FBITS-1:0] exp_data(input logic [WIDTH-1:0] s);
    logic [FBITS-1:0] v;
    logic [WIDTH-1:0] t;
    int               k;
    v = '0;
    for (int b = 0; b < FBITS; b++) begin
      k = b % SLOT;
      t = s >> (WIDTH - 1 - k);
      v = {v[FBITS-2:0], (k < WIDTH) ? t[0] : 1'b0};
    end
    return v;
  endfunction

  // Word select announces the channel of the next bit (one-bit I2S delay).
  function automatic logic [FBITS-1:0] exp_lr();
    logic [FBITS-1:0] v;
    v = '0;
    for (int b = 0; b < FBITS; b++) v = {v[FBITS-2:0], (((b + 1) / SLOT) % 2) == 1};
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] exp_underrun(input logic [WIDTH-1:0] last);
`ifdef WAVE_I2S_UNDERRUN_HOLD_EN
    return last;
`else
    return (last & '0);
`endif
  endfunction

  task automatic do_reset();
    valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] s, output bit ok);
    ok     = 1'b0;
    sample = s;
    valid  = 1'b1;
    for (int i = 0; i < 4 * FRAME_CYC && !ok; i++) begin
      @(negedge clk);
      if (o_sample_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    #1 valid = 1'b0;
  endtask

  task automatic collect_frame(output logic [FBITS-1:0] d, output logic [FBITS-1:0] lr,
                               output int t0, output bit ok);
    logic [1:0] r;
    int         w;
    d  = '0;
    lr = '0;
    t0 = 0;
    ok = 1'b1;
    for (int b = 0; b < FBITS; b++) begin
      w = 0;
      while (bitq.size() == 0 && w < 4 * FRAME_CYC) begin
        @(negedge clk);
        w++;
      end
      if (bitq.size() == 0) begin
        ok = 1'b0;
        return;
      end
      r = bitq.pop_front();
      if (b == 0) t0 = stampq[0];
      void'(stampq.pop_front());
      d  = {d[FBITS-2:0], r[0]};
      lr = {lr[FBITS-2:0], r[1]};
    end
  endtask

  task automatic test_reset();
    valid = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if ({o_bclk, o_lrclk, o_sdata, o_underrun, o_sample_ready} !== 5'b00001)
      $display("FAIL reset_hold: got %b expected 00001",
               {o_bclk, o_lrclk, o_sdata, o_underrun, o_sample_ready});
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (7) @(negedge clk);
      total++;
      if ({o_bclk, o_lrclk, o_sdata, o_underrun, o_sample_ready} !== 5'b00001)
        $display("FAIL idle_persist[%0d]: got %b expected 00001", i,
                 {o_bclk, o_lrclk, o_sdata, o_underrun, o_sample_ready});
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] s;
    logic [FBITS-1:0] d, lr;
    int               t_entry, t0, t1;
    bit               ok;
    s = 24'h800001;
    do_reset();
    send(s, ok);
    total++;
    if (!ok) $display("FAIL single_accept: timed out waiting for ready");
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({o_sample_ready, o_bclk, o_sdata} !== 3'b000)
      $display("FAIL single_hold_full: got %b expected 000", {o_sample_ready, o_bclk, o_sdata});
    else pass_cnt++;
    @(negedge clk);
    t_entry = cyc;
    total++;
    if ({o_bclk, o_lrclk, o_sdata, o_sample_ready} !== {2'b00, s[WIDTH-1], 1'b1})
      $display("FAIL single_entry: got %b expected %b",
               {o_bclk, o_lrclk, o_sdata, o_sample_ready}, {2'b00, s[WIDTH-1], 1'b1});
    else pass_cnt++;
    collect_frame(d, lr, t0, ok);
    total++;
    if (!ok || {d, lr} !== {exp_data(s), exp_lr()})
      $display("FAIL single_frame: got %h/%h expected %h/%h", d, lr, exp_data(s), exp_lr());
    else pass_cnt++;
    total++;
    if (t0 - t_entry !== BCLK_DIV)
      $display("FAIL single_first_rise: got %0d expected %0d", t0 - t_entry, BCLK_DIV);
    else pass_cnt++;
    collect_frame(d, lr, t1, ok);
    total++;
    if (!ok || {d, lr} !== {exp_data(exp_underrun(s)), exp_lr()})
      $display("FAIL single_frame2: got %h/%h expected %h/%h", d, lr,
               exp_data(exp_underrun(s)), exp_lr());
    else pass_cnt++;
    total++;
    if (t1 - t0 !== FRAME_CYC)
      $display("FAIL single_period: got %0d expected %0d", t1 - t0, FRAME_CYC);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] sv[3] = '{24'h123456, 24'hABCDEF, 24'h000000};
    logic [FBITS-1:0] d, lr;
    int               t0, u0, r0;
    bit               ok_s, ok_f;
    do_reset();
    u0 = ur_cnt;
    r0 = rdy_rise;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          send(sv[i], ok_s);
          total++;
          if (!ok_s) $display("FAIL stream_send[%0d]: timed out", i);
          else pass_cnt++;
        end
      end
      begin
        for (int i = 0; i < 3; i++) begin
          collect_frame(d, lr, t0, ok_f);
          total++;
          if (!ok_f || {d, lr} !== {exp_data(sv[i]), exp_lr()})
            $display("FAIL stream_frame[%0d]: got %h/%h expected %h/%h", i, d, lr,
                     exp_data(sv[i]), exp_lr());
          else pass_cnt++;
        end
      end
    join
    total++;
    if (ur_cnt - u0 !== 0) $display("FAIL stream_underrun: got %0d pulses expected 0", ur_cnt - u0);
    else pass_cnt++;
    total++;
    if (rdy_rise - r0 !== 3) $display("FAIL stream_ready_rises: got %0d expected 3", rdy_rise - r0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] sv[4];
    logic [FBITS-1:0] d, lr;
    int               t0, u0;
    bit               ok_s, ok_f;
    for (int i = 0; i < 4; i++) sv[i] = WIDTH'($urandom);
    do_reset();
    u0 = ur_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(sv[i], ok_s);
          if (!ok_s) begin
            total++;
            $display("FAIL random_send[%0d]: timed out", i);
          end
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          collect_frame(d, lr, t0, ok_f);
          total++;
          if (!ok_f || {d, lr} !== {exp_data(sv[i]), exp_lr()})
            $display("FAIL random_frame[%0d]: got %h/%h expected %h/%h", i, d, lr,
                     exp_data(sv[i]), exp_lr());
          else pass_cnt++;
        end
      end
    join
    total++;
    if (ur_cnt - u0 !== 0) $display("FAIL random_underrun: got %0d pulses expected 0", ur_cnt - u0);
    else pass_cnt++;
  endtask

  task automatic test_underrun();
    logic [WIDTH-1:0] s;
    logic [FBITS-1:0] d, lr;
    int               t0, u0, l0;
    bit               ok;
    s = 24'h7FFFFF;
    do_reset();
    u0 = ur_cnt;
    l0 = ur_long;
    send(s, ok);
    collect_frame(d, lr, t0, ok);
    total++;
    if (!ok || {d, lr} !== {exp_data(s), exp_lr()})
      $display("FAIL underrun_first: got %h/%h expected %h/%h", d, lr, exp_data(s), exp_lr());
    else pass_cnt++;
    total++;
    if (ur_cnt - u0 !== 0) $display("FAIL underrun_early: got %0d pulses expected 0", ur_cnt - u0);
    else pass_cnt++;
    collect_frame(d, lr, t0, ok);
    total++;
    if (!ok || {d, lr} !== {exp_data(exp_underrun(s)), exp_lr()})
      $display("FAIL underrun_frame: got %h/%h expected %h/%h", d, lr,
               exp_data(exp_underrun(s)), exp_lr());
    else pass_cnt++;
    total++;
    if (ur_cnt - u0 !== 1) $display("FAIL underrun_pulses: got %0d expected 1", ur_cnt - u0);
    else pass_cnt++;
    total++;
    if (ur_long - l0 !== 0) $display("FAIL underrun_width: got %0d extra cycles expected 0", ur_long - l0);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] sv[4];
    logic [FBITS-1:0] d, lr;
    int               t0, u0;
    bit               ok_s, ok_f;
    sv[0] = WIDTH'($urandom);
    sv[1] = WIDTH'($urandom);
    sv[2] = 24'h5A5A5A;
    do_reset();
    u0 = ur_cnt;
    fork
      begin
        send(sv[0], ok_s);
        send(sv[1], ok_s);
        sample = sv[2];
        valid  = 1'b1;
        @(negedge clk);
        total++;
        if (o_sample_ready !== 1'b0) $display("FAIL bp_ready: got %b expected 0", o_sample_ready);
        else pass_cnt++;
        send(sv[2], ok_s);
        total++;
        if (!ok_s) $display("FAIL bp_send: timed out");
        else pass_cnt++;
      end
      begin
        sv[3] = exp_underrun(sv[2]);
        for (int i = 0; i < 4; i++) begin
          collect_frame(d, lr, t0, ok_f);
          total++;
          if (!ok_f || {d, lr} !== {exp_data(sv[i]), exp_lr()})
            $display("FAIL bp_frame[%0d]: got %h/%h expected %h/%h", i, d, lr,
                     exp_data(sv[i]), exp_lr());
          else pass_cnt++;
        end
      end
    join
    total++;
    if (ur_cnt - u0 !== 1) $display("FAIL bp_underrun: got %0d pulses expected 1", ur_cnt - u0);
    else pass_cnt++;
  endtask

  task automatic test_midreset();
    logic [WIDTH-1:0] x, z, y;
    logic [FBITS-1:0] d, lr;
    int               t_entry, t0, w;
    bit               ok;
    x = WIDTH'($urandom);
    z = WIDTH'($urandom);
    y = WIDTH'($urandom) | 24'h800000;
    do_reset();
    send(x, ok);
    send(z, ok);
    w = 0;
    while (bitq.size() < 18 && w < 4 * FRAME_CYC) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (bitq.size() < 18) $display("FAIL midreset_reach_b17: got %0d bits expected 18", bitq.size());
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({o_bclk, o_lrclk, o_sdata, o_underrun, o_sample_ready} !== 5'b00001)
      $display("FAIL midreset_outputs: got %b expected 00001",
               {o_bclk, o_lrclk, o_sdata, o_underrun, o_sample_ready});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(y, ok);
    @(negedge clk);
    @(negedge clk);
    t_entry = cyc;
    total++;
    if ({o_bclk, o_lrclk, o_sdata} !== 3'b001)
      $display("FAIL midreset_entry: got %b expected 001", {o_bclk, o_lrclk, o_sdata});
    else pass_cnt++;
    collect_frame(d, lr, t0, ok);
    total++;
    if (!ok || {d, lr} !== {exp_data(y), exp_lr()})
      $display("FAIL midreset_frame: got %h/%h expected %h/%h", d, lr, exp_data(y), exp_lr());
    else pass_cnt++;
    total++;
    if (t0 - t_entry !== BCLK_DIV)
      $display("FAIL midreset_first_rise: got %0d expected %0d", t0 - t_entry, BCLK_DIV);
    else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_random();
    test_underrun();
    test_backpressure();
    test_midreset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
